regm_pipe: RTL and testbench
============================

# regm_pipe

Parametrised elastic pipeline register: a chain of `STAGES` clock-enabled data registers with a per-stage valid bit and a valid/ready handshake. It is the multi-stage, back-pressure-aware successor to the single enable register used between CPU datapath stages. Bubbles collapse: an empty stage accepts new data even while stages downstream are stalled. It sits between producer and consumer pipeline stages of the CPU. A `flush` input discards all in-flight words on a branch or exception.

## Interface
Parameters:
- `WIDTH`, default 32: data width in bits.
- `STAGES`, default 2: number of register stages. Legal range is 1..16.

Ports:
- `clk`, input, 1 bit: the single clock. All state changes on the rising edge.
- `reset`, input, 1 bit: reset, asynchronous and active-high. Clears all state immediately.
- `flush`, input, 1 bit: synchronous clear of all valid bits.
- `in_valid`, input, 1 bit: producer has a word on `din`.
- `in_ready`, output, 1 bit: stage 0 can accept a word this cycle.
- `din`, input, `WIDTH` bits: input word.
- `out_valid`, output, 1 bit: the last stage holds a valid word.
- `out_ready`, input, 1 bit: consumer takes the word this cycle.
- `dout`, output, `WIDTH` bits: data of the last stage.
- `count`, output, `$clog2(STAGES+1)` bits: number of valid stages, registered.

## Operation
- State per stage i (0 = input side, STAGES-1 = output side):
  - `v[i]`, the valid bit.
  - `d[i]`, the `WIDTH`-bit data register.
- Ready chain, combinational:
  - `rdy[STAGES-1] = !v[STAGES-1] || out_ready`.
  - `rdy[i] = !v[i] || rdy[i+1]`.
  - `in_ready = rdy[0]`.
- Stage enable: `en[i] = rdy[i]`.
- On an edge with `en[i]` asserted:
  - Stage i loads from stage i-1: `v[i] <= v[i-1]` and `d[i] <= d[i-1]`.
  - Stage 0 loads from the input: `v[0] <= in_valid` and `d[0] <= din`.
- A stage with `en[i]` low holds both `v` and `d`.
- Data registers load only when `en[i]` is high. A bubble (`v[i-1]=0`) still loads `d[i]`; the content is don't-care because `v[i]` goes to 0.
- Transfers:
  - Input transfer is `in_valid && in_ready`.
  - Output transfer is `out_valid && out_ready`.
  - A word is never duplicated or dropped except by `flush`.
- Outputs: `out_valid = v[STAGES-1]` and `dout = d[STAGES-1]`. `dout` is stale when `out_valid=0`.
- `count`:
  - Registered value, equal to the population of the next-state `v`.
  - Changes by +1, -1 or 0 per cycle, or drops to 0 on `flush`.
- `flush`:
  - Has priority over all transfers.
  - Next edge: all `v` become 0 and `count` becomes 0.
  - `d` registers may load or hold as they would without `flush`; they are don't-care.
  - `in_ready` stays as computed, but any `din` offered during a `flush` cycle is discarded.
  - `out_valid` and `dout` keep their current-cycle values, so a consumer may still take the word during the flush cycle.
- `reset`: all `v`, all `d` and `count` are forced to 0 asynchronously. Outputs are `out_valid=0`, `dout=0`, `count=0`. `in_ready` is 1 while `reset` is held.
- Reset mid-operation discards every in-flight word. The first edge after deassertion behaves exactly as after power-up.

## Timing
- Latency: a word accepted at edge N appears on `dout`/`out_valid` after edge N+STAGES-1. With STAGES=1 it appears after edge N itself, i.e. the cycle following acceptance.
- Throughput: one word per cycle when `out_ready` is held high.
- `in_ready` is a combinational function of `out_ready` and the `v` bits, with depth O(STAGES). No combinational path exists from `in_valid` or `din` to any output.
- Full: all `v=1` and `out_ready=0` gives `in_ready=0`. A simultaneous push and pop while full is allowed; `in_ready` follows `out_ready` and `count` stays at STAGES.
- Empty: `count=0` and `out_valid=0`. Any input is accepted.

## Test plan
- Reset with STAGES=3, WIDTH=32: assert `reset` with no clock.
  - Required: `out_valid=0`, `dout=0`, `count=0` and `in_ready=1` immediately.
- Streaming: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready=1`.
  - Required: 0x11 on `dout` with `out_valid=1` in the third cycle after its accept edge. One word per cycle thereafter, in order. `count` settles at 3.
- Stall and fill: `out_ready=0` and push 0xA, 0xB, 0xC, 0xD.
  - Required: 0xA, 0xB and 0xC are accepted. `in_ready=0` when the fourth word is offered. `count=3`. `dout=0xA` is held.
  - Then raise `out_ready`. Required: the output sequence is 0xA, 0xB, 0xC, 0xD with no loss.
- Bubble collapse: with stage 2 valid, a stalled output and stages 0–1 empty, push one word.
  - Required: it advances into stage 1 while stage 2 holds. `count` goes from 1 to 2.
- Flush: with the pipe full, pulse `flush` for one cycle while `in_valid=1`.
  - Required: next cycle `out_valid=0` and `count=0`. The word offered during the flush never appears at the output.
- Async reset mid-stream: assert `reset` between clock edges while `count=2`.
  - Required: `count` and `out_valid` drop to 0 before the next edge. After deassertion, the first word pushed emerges after the normal STAGES-cycle latency.

Source files
------------

// File: rtl/regm_pipe.sv
// regm_pipe: elastic multi-stage pipeline register with valid/ready handshake,
// bubble collapse, synchronous flush and a registered occupancy count.
module regm_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            din,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            dout,
    output logic [$clog2(STAGES+1)-1:0] count
);
    localparam int CW = $clog2(STAGES+1);

    function automatic logic [CW-1:0] popcount(input logic [STAGES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < STAGES; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_n;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    // Ready chain: a stage can move when it is empty or everything downstream can move
    always_comb begin : ready_chain
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r      = r | ~v_q[i];
            rdy[i] = r;
        end
    end

    // Next-state valid/data per stage; flush only clears valids, data is don't-care
    always_comb begin
        v_n = v_q;
        d_d = d_q;
        if (rdy[0]) begin
            v_n[0] = in_valid;
            d_d[0] = din;
        end else begin
            v_n[0] = v_q[0];
            d_d[0] = d_q[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
                v_n[i] = v_q[i-1];
                d_d[i] = d_q[i-1];
            end else begin
                v_n[i] = v_q[i];
                d_d[i] = d_q[i];
            end
        end
        if (flush) begin
            v_d = '0;
        end else begin
            v_d = v_n;
        end
        count_d = popcount(v_d);
    end

    // Pipeline state and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign dout      = d_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_regm_pipe.sv
// Self-checking bench for regm_pipe (STAGES=3, WIDTH=32): directed scenarios
// followed by random traffic, all checked against a slot-compaction model.
module tb_regm_pipe;
    localparam int S = 3;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  din;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  dout;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;

    // Model: S slots, output side is slot S-1
    logic [S-1:0]  mv;
    logic [W-1:0]  md [S];
    logic [W-1:0]  got [$];

    regm_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        mv = '0;
        for (int i = 0; i < S; i++) md[i] = '0;
    endtask

    // Pop the head if taken, slide every word forward into free slots, then fill slot 0
    task automatic model_step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        if (mv[S-1] && ordy) mv[S-1] = 1'b0;
        for (int i = S - 1; i >= 1; i--) begin
            if (!mv[i]) begin
                mv[i]   = mv[i-1];
                md[i]   = md[i-1];
                mv[i-1] = 1'b0;
            end
        end
        if (!mv[0]) begin
            mv[0] = iv;
            md[0] = d;
        end
        if (fl) mv = '0;
    endtask

    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl,
                         output bit acc);
        bit exp_rdy;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = ($countones(mv) < S) || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = iv && in_ready;
        if (out_valid && ordy) got.push_back(dout);
        model_step(iv, d, ordy, fl);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(mv[S-1]));
        chk("count", 32'(count), 32'($countones(mv)));
        if (mv[S-1]) chk("dout", dout, md[S-1]);
    endtask

    task automatic chk_got(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_len"}, 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk(tag, got[i], e[i]);
    endtask

    initial begin
        bit acc;
        int n;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming
        got.delete();
        cycle(1'b1, 32'h11, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h22, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h33, 1'b1, 1'b0, acc);
        chk("stream_first_valid", 32'(out_valid), 32'd1);
        chk("stream_first_dout", dout, 32'h11);
        cycle(1'b1, 32'h44, 1'b1, 1'b0, acc);
        chk("stream_count", 32'(count), 32'd3);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk_got("stream_order", 32'h11, 32'h22, 32'h33, 32'h44);

        // Stall and fill
        got.delete();
        cycle(1'b1, 32'hA, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, acc);
        chk("fill_count", 32'(count), 32'd3);
        cycle(1'b1, 32'hD, 1'b0, 1'b0, acc);
        chk("fill_d_rejected", 32'(acc), 32'd0);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_dout_held", dout, 32'hA);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 8) begin
            cycle(1'b1, 32'hD, 1'b1, 1'b0, acc);
            n++;
        end
        chk("fill_d_accepted", 32'(acc), 32'd1);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk_got("fill_order", 32'hA, 32'hB, 32'hC, 32'hD);

        // Bubble collapse
        cycle(1'b1, 32'h5A, 1'b0, 1'b0, acc);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        chk("bubble_count1", 32'(count), 32'd1);
        cycle(1'b1, 32'h6B, 1'b0, 1'b0, acc);
        chk("bubble_count2", 32'(count), 32'd2);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        chk("bubble_dout_held", dout, 32'h5A);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("bubble_next_dout", dout, 32'h6B);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // Flush with a full pipe and a word offered in the flush cycle
        cycle(1'b1, 32'hC1, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hC2, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hC3, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hF1, 1'b0, 1'b1, acc);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        got.delete();
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("flush_no_output", 32'(got.size()), 32'd0);

        // Asynchronous reset mid-stream
        cycle(1'b1, 32'hD1, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hD2, 1'b0, 1'b0, acc);
        chk("arst_pre_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        #2;
        reset = 1'b0;
        cycle(1'b1, 32'hE1, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("arst_latency_early", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("arst_latency_valid", 32'(out_valid), 32'd1);
        chk("arst_latency_dout", dout, 32'hE1);

        // Random traffic
        repeat (400) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
